alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle `adder` ALU; same operand/opcode/result datapath.
- Generalised in operand width and pipeline depth.
- Adds valid/ready handshakes on input and output, optional saturating arithmetic, status flags and a delivered-result counter.
- Sits between the stimulus driver interface and the scoreboard-facing monitor.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_pipe_if.sv | 37 +++
 rtl/alu_pipe_stage.sv | 36 +++
 rtl/alu_pipe.sv | 154 +++++++++++++++
 tb/tb_alu_pipe.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined ALU: opcode encoding,
// status-flag layout and the shift-amount width calculation.
package alu_pkg;

  // Operation select carried on the 3-bit opcode field.
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_PASSA = 3'd7
  } opcode_e;

  // Status flags travelling alongside each result.
  typedef struct packed {
    logic carry;  // carry out of ADD, borrow out of SUB
    logic ovf;    // signed overflow of ADD/SUB
    logic zero;   // final (post-saturation) result is all zeros
  } alu_flags_t;

  localparam int DEFAULT_WIDTH = 8;

  // Number of low b bits used as the shift amount for a given width.
  function automatic int calc_shamt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int SHAMT_W = calc_shamt_w(DEFAULT_WIDTH);

endpackage : alu_pkg

// File: rtl/alu_pipe_if.sv
// Operand/result bus of the pipelined ALU.
//
// Handshake semantics (both directions): a transfer happens at a rising clk
// edge where valid && ready are both 1. The producer keeps valid and its
// payload stable until the transfer happens; ready may change freely and is
// never a function of valid on the same side. The input side is
// in_valid/in_ready with a, b, opcode; the output side is out_valid/out_ready
// with c and flags. res_count counts completed output transfers.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic [15:0]      res_count;

  // Stimulus / consumer side.
  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, c, carry, ovf, zero, res_count
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, c, carry, ovf, zero, res_count
  );

endinterface : alu_pipe_if

// File: rtl/alu_pipe_stage.sv
// One pipeline slice: a valid bit plus a data word. When i_load is high the
// slice takes whatever its upstream offers (possibly a bubble); otherwise it
// holds. Data only changes when a valid item arrives, so the result bus stays
// quiet across bubbles.
module alu_pipe_stage #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Load-or-hold register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : alu_pipe_stage

// File: rtl/alu_pipe.sv
// Pipelined ALU. The operation is evaluated combinationally from the input
// bus and captured in stage 0 on accept; later stages only move the result
// and flags towards the output. Each stage loads when it is empty or when its
// successor drains it in the same cycle, giving STAGES entries of storage and
// full throughput under continuous flow.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  localparam int L_SHAMT_W = calc_shamt_w(WIDTH);
  localparam int DW        = WIDTH + $bits(alu_flags_t);

  // ---------------------------------------------------------------------------
  // Compute
  // ---------------------------------------------------------------------------
  opcode_e              w_op;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [L_SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]     w_c;
  alu_flags_t           w_flags;
  logic                 w_a_msb;
  logic                 w_b_msb;

  assign w_op    = opcode_e'(bus.opcode);
  assign w_shamt = bus.b[L_SHAMT_W-1:0];
  assign w_a_msb = bus.a[WIDTH-1];
  assign w_b_msb = bus.b[WIDTH-1];

  // Evaluate the selected operation, flags and optional saturation.
  always_comb begin
    w_sum         = {1'b0, bus.a} + {1'b0, bus.b};
    w_diff        = {1'b0, bus.a} - {1'b0, bus.b};
    w_c           = '0;
    w_flags.carry = 1'b0;
    w_flags.ovf   = 1'b0;
    w_flags.zero  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_c           = w_sum[WIDTH-1:0];
        w_flags.carry = w_sum[WIDTH];
        // Same-sign operands producing a different-sign result.
        w_flags.ovf   = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
        if ((SATURATE != 0) && w_sum[WIDTH]) begin
          w_c = '1;
        end
      end
      OP_SUB: begin
        w_c           = w_diff[WIDTH-1:0];
        // The extra bit of the widened difference is the unsigned borrow.
        w_flags.carry = w_diff[WIDTH];
        // Opposite-sign operands with the result sign differing from a.
        w_flags.ovf   = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
        if ((SATURATE != 0) && w_diff[WIDTH]) begin
          w_c = '0;
        end
      end
      OP_AND:  w_c = bus.a & bus.b;
      OP_OR:   w_c = bus.a | bus.b;
      OP_XOR:  w_c = bus.a ^ bus.b;
      OP_SHL:  w_c = bus.a << w_shamt;
      OP_SHR:  w_c = bus.a >> w_shamt;
      default: w_c = bus.a;
    endcase
    // Zero reflects the value that is actually delivered.
    w_flags.zero = (w_c == '0);
  end

  // ---------------------------------------------------------------------------
  // Pipeline and flow control
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_load;
  logic [DW-1:0]     w_data [STAGES];

  // Stage k may load when the output drains this cycle or any stage from k
  // downstream has a hole; this is the unrolled form of the per-stage
  // "empty or successor takes it" chain.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_load[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!w_valid[j]) begin
          w_load[k] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          w_in_valid;
      logic [DW-1:0] w_in_data;

      if (k == 0) begin : g_head
        assign w_in_valid = bus.in_valid;
        assign w_in_data  = {w_c, w_flags};
      end else begin : g_body
        assign w_in_valid = w_valid[k-1];
        assign w_in_data  = w_data[k-1];
      end

      alu_pipe_stage #(
        .DW (DW)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load[k]),
        .i_valid (w_in_valid),
        .i_data  (w_in_data),
        .o_valid (w_valid[k]),
        .o_data  (w_data[k])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------------
  alu_flags_t       w_out_flags;
  logic [WIDTH-1:0] w_out_c;
  logic             w_deliver;
  logic [15:0]      r_res_count;

  assign {w_out_c, w_out_flags} = w_data[STAGES-1];
  assign w_deliver              = w_valid[STAGES-1] && bus.out_ready;

  // Count delivered results; 16-bit wrap is intentional.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_count <= '0;
    end else if (w_deliver) begin
      r_res_count <= r_res_count + 16'd1;
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.c         = w_out_c;
  assign bus.carry     = w_out_flags.carry;
  assign bus.ovf       = w_out_flags.ovf;
  assign bus.zero      = w_out_flags.zero;
  assign bus.res_count = r_res_count;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8, STAGES=2). Two instances share one stimulus
// stream: one plain, one saturating. A reference model predicts every result
// from the arithmetic rules; a per-cycle monitor compares against it, and
// directed vectors pin literal values.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) if0 ();
  alu_pipe_if #(.WIDTH(W)) if_s ();

  alu_pipe #(.WIDTH(W), .STAGES(S), .SATURATE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  alu_pipe #(.WIDTH(W), .STAGES(S), .SATURATE(1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s.slave)
  );

  assign if_s.in_valid  = if0.in_valid;
  assign if_s.a         = if0.a;
  assign if_s.b         = if0.b;
  assign if_s.opcode    = if0.opcode;
  assign if_s.out_ready = if0.out_ready;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [W+2:0] exp_q[$];
  logic [W+2:0] exp_s_q[$];
  logic [15:0]  exp_count;
  logic [15:0]  exp_count_s;
  logic         exp_ready;
  logic         stream_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {c, carry, ovf, zero} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input bit sat);
    int ia, ib, sa, sb, r, sr;
    logic cy, ov;
    logic [W-1:0] c;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    cy = 1'b0;
    ov = 1'b0;
    c  = '0;
    case (op)
      3'd0: begin
        r  = ia + ib;
        cy = (r > 255);
        c  = 8'(r % 256);
        sr = sa + sb;
        ov = (sr > 127) || (sr < -128);
        if (sat && cy) c = 8'hFF;
      end
      3'd1: begin
        r  = ia - ib;
        cy = (ia < ib);
        c  = 8'((r + 256) % 256);
        sr = sa - sb;
        ov = (sr > 127) || (sr < -128);
        if (sat && cy) c = 8'h00;
      end
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = a ^ b;
      3'd5: c = 8'((ia * (2 ** (ib % 8))) % 256);
      3'd6: c = 8'(ia / (2 ** (ib % 8)));
      default: c = a;
    endcase
    return {c, cy, ov, (c == 8'h00)};
  endfunction

  // Per-cycle compare at mid-cycle, then advance the model for the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_s_q.delete();
      exp_count   = '0;
      exp_count_s = '0;
    end else begin
      exp_ready = (exp_q.size() < S) || if0.out_ready;
      chk("in_ready", {31'b0, if0.in_ready}, {31'b0, exp_ready});
      chk("in_ready_sat", {31'b0, if_s.in_ready}, {31'b0, exp_ready});
      chk("res_count", {16'b0, if0.res_count}, {16'b0, exp_count});
      chk("res_count_sat", {16'b0, if_s.res_count}, {16'b0, exp_count_s});

      if (exp_q.size() == 0) chk("idle_out_valid", {31'b0, if0.out_valid}, 32'd0);
      else if (if0.out_valid)
        chk("result", {21'b0, if0.c, if0.carry, if0.ovf, if0.zero}, {21'b0, exp_q[0]});
      if (exp_s_q.size() == 0) chk("idle_out_valid_sat", {31'b0, if_s.out_valid}, 32'd0);
      else if (if_s.out_valid)
        chk("result_sat", {21'b0, if_s.c, if_s.carry, if_s.ovf, if_s.zero}, {21'b0, exp_s_q[0]});

      if (if0.out_valid && if0.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_count = exp_count + 16'd1;
      end
      if (if_s.out_valid && if_s.out_ready && exp_s_q.size() > 0) begin
        void'(exp_s_q.pop_front());
        exp_count_s = exp_count_s + 16'd1;
      end
      if (if0.in_valid && exp_ready) begin
        exp_q.push_back(model(if0.opcode, if0.a, if0.b, 1'b0));
        exp_s_q.push_back(model(if0.opcode, if0.a, if0.b, 1'b1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+2, return at posedge+2)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    int n;
    n = 0;
    if0.opcode   = op;
    if0.a        = av;
    if0.b        = bv;
    if0.in_valid = 1'b1;
    @(negedge clk);
    while (!if0.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", {31'b0, if0.in_ready}, 32'd1);
    step();
    if0.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [7:0] c, input logic cy,
                            input logic ov, input logic z, input logic [7:0] cs,
                            input logic zs, input int max_wait);
    int n;
    n = 0;
    @(negedge clk);
    while (!(if0.out_valid && if0.out_ready) && n < max_wait) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_valid"}, {31'b0, if0.out_valid}, 32'd1);
    chk(name, {21'b0, if0.c, if0.carry, if0.ovf, if0.zero}, {21'b0, c, cy, ov, z});
    chk({name, "_sat"}, {21'b0, if_s.c, if_s.carry, if_s.ovf, if_s.zero}, {21'b0, cs, cy, ov, zs});
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    if0.in_valid  = 1'b0;
    if0.a         = '0;
    if0.b         = '0;
    if0.opcode    = '0;
    if0.out_ready = 1'b1;
    stream_done   = 1'b0;

    // Reset held for three cycles.
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", {31'b0, if0.out_valid}, 32'd0);
    chk("rst_c_flags", {21'b0, if0.c, if0.carry, if0.ovf, if0.zero}, 32'd0);
    chk("rst_res_count", {16'b0, if0.res_count}, 32'd0);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, if0.in_ready}, 32'd1);
    step();

    // ADD with carry, and exact two-cycle latency.
    do_op(3'd0, 8'hF0, 8'h20);
    @(negedge clk);
    chk("add_lat_early", {31'b0, if0.out_valid}, 32'd0);
    step();
    expect_res("add_f0_20", 8'h10, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 0);

    do_op(3'd0, 8'h7F, 8'h01);
    expect_res("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 5);

    do_op(3'd1, 8'h10, 8'h20);
    expect_res("sub_10_20", 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5);

    do_op(3'd5, 8'h81, 8'h09);
    expect_res("shl_81_9", 8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 5);

    do_op(3'd6, 8'h80, 8'h07);
    expect_res("shr_80_7", 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 5);

    do_op(3'd4, 8'hAA, 8'hAA);
    expect_res("xor_aa_aa", 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5);

    // Back-to-back stream over all opcodes with intermittent backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++) do_op(3'(i % 8), 8'(i * 37 + 5), 8'(i * 91 + 3));
        stream_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!stream_done) begin
          if0.out_ready = ((k % 3) != 0);
          k++;
          step();
        end
      end
    join
    if0.out_ready = 1'b1;
    repeat (6) step();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: two held, third pending, then drain in order.
    pulse_reset();
    if0.out_ready = 1'b0;
    do_op(3'd0, 8'h01, 8'h01);
    do_op(3'd0, 8'h02, 8'h02);
    if0.opcode   = 3'd0;
    if0.a        = 8'h03;
    if0.b        = 8'h03;
    if0.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full_ready_0", {31'b0, if0.in_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_full_ready_1", {31'b0, if0.in_ready}, 32'd0);
    chk("bp_hold_c", {24'b0, if0.c}, 32'h02);
    step();
    if0.out_ready = 1'b1;
    expect_res("bp_0", 8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 0);
    if0.in_valid = 1'b0;
    expect_res("bp_1", 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 0);
    expect_res("bp_2", 8'h06, 1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 0);
    @(negedge clk);
    chk("bp_res_count", {16'b0, if0.res_count}, 32'd3);
    step();

    // Reset between edges with two ops in flight.
    if0.out_ready = 1'b0;
    do_op(3'd0, 8'h05, 8'h05);
    do_op(3'd0, 8'h06, 8'h06);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'b0, if0.out_valid}, 32'd0);
    chk("rst_mid_out_valid_sat", {31'b0, if_s.out_valid}, 32'd0);
    chk("rst_mid_res_count", {16'b0, if0.res_count}, 32'd0);
    step();
    step();
    reset = 1'b1;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_quiet", {31'b0, if0.out_valid}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("rst_mid_count_after", {16'b0, if0.res_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_pipe
